dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Arbitrates single-port 16x4 data memory between the micro core (CPU port) and an external host/debug port (host port).
- Sits between the computational unit's data-memory address/data/write-enable and the data_memory instance. Drives that memory's address, data and wren.
- CPU has priority. A wait counter bounds host starvation by forcing a host slot and stalling the CPU for one cycle.

Parameters:
- ADDR_W, 4, data memory address width.
- DATA_W, 4, data memory word width.
- MAX_WAIT, 8, consecutive denied host cycles before a forced host grant (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU needs memory this cycle (read or write).
- cpu_wren  in  1  CPU write strobe, qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU access not serviced this cycle; core must hold its access.
- host_req  in  1  host request; held with stable addr/data/we until host_gnt.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle pulse: host access performed this cycle.
- host_rdata  out  DATA_W  registered read data.
- host_rvalid  out  1  host_rdata valid, one cycle after a read grant.
- mem_addr  out  ADDR_W  to data memory address.
- mem_wdata  out  DATA_W  to data memory data.
- mem_wren  out  1  to data memory wren.
- mem_q  in  DATA_W  data memory output; valid before the next rising edge (memory clocked on inverted clk).

Behaviour:
- Registered state:
  - wait_cnt, 4 bits, saturating at MAX_WAIT.
  - rd_pend, 1 bit.
  - host_rdata.
- Owner decision is combinational each cycle, evaluated in priority order:
  1. reset=1 → owner NONE. mem_wren=0, host_gnt=0, cpu_stall=0, mem_addr=cpu_addr.
  2. host_req && wait_cnt==MAX_WAIT → owner HOST (forced). cpu_stall=cpu_req.
  3. cpu_req → owner CPU. host not granted.
  4. host_req → owner HOST.
  5. Otherwise owner CPU (idle default). mem_wren=0.
- Memory mux:
  - Owner CPU: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_wren=cpu_req&cpu_wren.
  - Owner HOST: mem_addr=host_addr, mem_wdata=host_wdata, mem_wren=host_we. host_gnt=1.
- wait_cnt update on each rising edge:
  - reset → 0.
  - host granted → 0.
  - host_req && !host_gnt → min(wait_cnt+1, MAX_WAIT).
  - !host_req → 0 (a withdrawn request forfeits accumulated wait).
- Read path:
  - On a host read grant, rd_pend<=1 and host_rdata<=mem_q at the end of the grant cycle.
  - host_rvalid=rd_pend in the next cycle (latency 1).
  - host_rdata holds its value until the next host read.
- Write path: a host write takes effect in the grant cycle. No rvalid is generated.
- Back-to-back host grants are allowed every cycle while cpu_req=0. A read then a write to the same address returns the pre-write data.
- Fairness:
  - After a forced grant, wait_cnt=0, so the CPU wins the next cycle.
  - The CPU is stalled at most 1 cycle in every MAX_WAIT+1 cycles.
  - With cpu_req held high, a pending host request is granted exactly on its (MAX_WAIT+1)th cycle.
- cpu_stall is asserted only when cpu_req=1 and owner=HOST. It is never asserted during reset.
- Reset mid-operation:
  - A pending rvalid is cancelled: rd_pend<=0 and host_rdata<=0.
  - All outputs are 0 the cycle after reset, except the mem_addr/mem_wdata mux values.
- No two writes can collide: exactly one owner per cycle.

Optional Feature:
- Macro: DM_ARB_STALL_CNT_EN.
- Defined: adds output stall_count [7:0], which:
  - increments on every cycle with cpu_stall=1;
  - saturates at 255;
  - clears on reset.
- Undefined: the port is absent; behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles with cpu_req=1, host_req=1 → mem_wren=0, host_gnt=0, cpu_stall=0, host_rvalid=0. Cycle after release: CPU owns.
- cpu_req=0; host write addr 0x3 data 0xA, then host read addr 0x3 → host_gnt pulses in both cycles. Cycle after the read grant: host_rvalid=1, host_rdata=0xA.
- cpu_req=1 continuously (writing addr 0x5); host read addr 0x5 asserted at cycle 0 (MAX_WAIT=8) → host denied cycles 0-7. Cycle 8: host_gnt=1, cpu_stall=1. Cycle 9: CPU owns, cpu_stall=0.
- host_req raised for 5 cycles under cpu_req=1, dropped, then re-raised → wait_cnt restarts from 0. No forced grant until 8 further denied cycles.
- cpu_req=0 and host_req=1 for 4 consecutive reads of addrs 0..3 preloaded 0x1..0x4 → host_gnt=1 for 4 cycles. host_rdata = 0x1,0x2,0x3,0x4 on the following 4 cycles.
- Host read granted, then reset asserted the next cycle → host_rvalid=0 and host_rdata=0. With DM_ARB_STALL_CNT_EN defined, the third scenario repeated 3 times gives stall_count=3.

Source files
------------

// File: rtl/dm_arbiter.sv
// ============================================================================
// Module      : dm_arbiter
// Description : Shares the single-port data memory between the CPU (priority)
//               and a host/debug port, with a wait counter that forces a host
//               slot. Optional stall counter enabled by DM_ARB_STALL_CNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dm_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
`ifdef DM_ARB_STALL_CNT_EN
  output logic [7:0]        stall_count,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  logic [3:0]        r_wait_cnt;
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_host_rdata;
  logic              w_forced;
  logic              w_host_own;
  logic              w_host_rd;

  // Host owns the memory when starved long enough or when the CPU is idle.
  always_comb begin
    w_forced   = host_req && (r_wait_cnt == c_max_wait);
    w_host_own = !reset && host_req && (w_forced || !cpu_req);
    w_host_rd  = w_host_own && !host_we;
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wren  = 1'b0;
    if (w_host_own) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wren  = host_we;
    end else if (!reset) begin
      mem_wren  = cpu_req && cpu_wren;
    end
  end

  assign host_gnt    = w_host_own;
  assign cpu_stall   = w_host_own && cpu_req;
  assign host_rvalid = r_rd_pend;
  assign host_rdata  = r_host_rdata;

  // A withdrawn request forfeits its accumulated wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
    end else if (w_host_own || !host_req) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != c_max_wait) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // mem_q is valid before the rising edge since memory runs on inverted clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend    <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_rd_pend <= w_host_rd;
      if (w_host_rd) begin
        r_host_rdata <= mem_q;
      end
    end
  end

`ifdef DM_ARB_STALL_CNT_EN
  logic [7:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 8'd0;
    end else if (cpu_stall && (r_stall_count != 8'hFF)) begin
      r_stall_count <= r_stall_count + 8'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a rule-level model with a shadow memory.
`default_nettype none

module tb_dm_arbiter;

  localparam int MAX_WAIT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_wren, cpu_stall;
  logic [3:0] cpu_addr, cpu_wdata;
  logic       host_req, host_we, host_gnt, host_rvalid;
  logic [3:0] host_addr, host_wdata, host_rdata;
  logic [3:0] mem_addr, mem_wdata, mem_q;
  logic       mem_wren;
`ifdef DM_ARB_STALL_CNT_EN
  logic [7:0] stall_count;
`endif

  logic [3:0] tmem [16];

  int n_pass  = 0;
  int n_total = 0;

  dm_arbiter #(.ADDR_W(4), .DATA_W(4), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
`ifdef DM_ARB_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Data memory clocked on the inverted clock.
  always @(negedge clk) begin
    if (mem_wren) tmem[mem_addr] <= mem_wdata;
    mem_q <= tmem[mem_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = 4'h0; cpu_wdata = 4'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 4'h0; host_wdata = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic rst, creq, cwe; logic [3:0] ca, cd;
    logic hreq, hwe;      logic [3:0] ha, hd;
    logic gnt, stall, wren; logic [3:0] addr; logic rv; logic [3:0] rd;
  } vec_t;

  vec_t tbl [9];

  task automatic forced_seq();
    cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 4'h5; cpu_wdata = 4'h9;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'h5;
    for (int c = 0; c <= MAX_WAIT; c++) begin
      #6;
      chk($sformatf("forced_gnt_c%0d", c), host_gnt, (c == MAX_WAIT) ? 1 : 0);
      chk($sformatf("forced_stall_c%0d", c), cpu_stall, (c == MAX_WAIT) ? 1 : 0);
      chk($sformatf("forced_wren_c%0d", c), mem_wren, (c == MAX_WAIT) ? 0 : 1);
      tick();
    end
    host_req = 1'b0;
    #6;
    chk("after_forced_gnt", host_gnt, 0);
    chk("after_forced_stall", cpu_stall, 0);
    chk("after_forced_rvalid", host_rvalid, 1);
    chk("after_forced_rdata", host_rdata, 9);
    tick();
  endtask

  int         denied;
  logic       ev, hact, eg, est, ewr;
  logic [3:0] erd, ead, ewd;
  logic [3:0] sh [16];

  initial begin
    for (int i = 0; i < 16; i++) tmem[i] = 4'h0;
    idle_inputs();
    //        rst   creq  cwe   ca    cd    hreq  hwe   ha    hd    gnt   stall wren  addr  rv    rd
    tbl[0] = '{1'b1, 1'b1, 1'b1, 4'h2, 4'h7, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 4'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 4'h2, 4'h7, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 4'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 4'h2, 4'h7, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h3, 4'hA, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 4'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 4'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'hA};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 4'hA};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h2, 4'h5, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1, 4'h7};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h7};

    tick();
    do_reset();

    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; cpu_req = tbl[i].creq; cpu_wren = tbl[i].cwe;
      cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd; host_req = tbl[i].hreq;
      host_we = tbl[i].hwe; host_addr = tbl[i].ha; host_wdata = tbl[i].hd;
      #6;
      chk($sformatf("vec%0d_gnt", i), host_gnt, tbl[i].gnt);
      chk($sformatf("vec%0d_stall", i), cpu_stall, tbl[i].stall);
      chk($sformatf("vec%0d_wren", i), mem_wren, tbl[i].wren);
      chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_rvalid", i), host_rvalid, tbl[i].rv);
      chk($sformatf("vec%0d_rdata", i), host_rdata, tbl[i].rd);
      tick();
    end

    // Forced host slot under continuous CPU traffic, three times in a row.
    do_reset();
    for (int r = 0; r < 3; r++) forced_seq();
`ifdef DM_ARB_STALL_CNT_EN
    #6;
    chk("stall_count", stall_count, 3);
    tick();
`endif

    // Withdrawn request restarts the wait count.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 4'h1; host_req = 1'b1; host_addr = 4'h1;
    for (int c = 0; c < 5; c++) begin
      #6; chk($sformatf("withdraw_pre_c%0d", c), host_gnt, 0); tick();
    end
    host_req = 1'b0;
    #6; chk("withdraw_gap", host_gnt, 0); tick();
    host_req = 1'b1;
    for (int c = 0; c <= MAX_WAIT; c++) begin
      #6;
      chk($sformatf("withdraw_post_c%0d", c), host_gnt, (c == MAX_WAIT) ? 1 : 0);
      tick();
    end
    idle_inputs();
    tick();

    // Back-to-back host writes then reads with the CPU idle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 4'(i); host_wdata = 4'(i + 1);
      #6; chk($sformatf("b2b_wr_gnt%0d", i), host_gnt, 1); tick();
    end
    for (int i = 0; i < 4; i++) begin
      host_we = 1'b0; host_addr = 4'(i);
      #6;
      chk($sformatf("b2b_rd_gnt%0d", i), host_gnt, 1);
      if (i > 0) begin
        chk($sformatf("b2b_rvalid%0d", i), host_rvalid, 1);
        chk($sformatf("b2b_rdata%0d", i), host_rdata, i);
      end
      tick();
    end
    host_req = 1'b0;
    #6;
    chk("b2b_rvalid_last", host_rvalid, 1);
    chk("b2b_rdata_last", host_rdata, 4);
    tick();

    // Reset right after a read grant cancels the pending read.
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'h2;
    #6; chk("cancel_gnt", host_gnt, 1); tick();
    host_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #6;
    chk("cancel_rvalid", host_rvalid, 0);
    chk("cancel_rdata", host_rdata, 0);
    chk("cancel_gnt_after", host_gnt, 0);
    chk("cancel_wren_after", mem_wren, 0);
    tick();

    // Random traffic against the rule-level model.
    do_reset();
    for (int i = 0; i < 16; i++) sh[i] = tmem[i];
    denied = 0; ev = 1'b0; erd = 4'h0; hact = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_wren  = 1'($urandom_range(0, 1));
      cpu_addr  = 4'($urandom_range(0, 15));
      cpu_wdata = 4'($urandom_range(0, 15));
      if (!hact && $urandom_range(0, 2) == 0) begin
        hact = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 4'($urandom_range(0, 15));
        host_wdata = 4'($urandom_range(0, 15));
      end else if (hact && $urandom_range(0, 19) == 0) begin
        hact = 1'b0;
      end
      host_req = hact;

      eg  = !reset && host_req && (denied >= MAX_WAIT || !cpu_req);
      est = eg && cpu_req;
      ead = eg ? host_addr : cpu_addr;
      ewd = eg ? host_wdata : cpu_wdata;
      ewr = reset ? 1'b0 : (eg ? host_we : (cpu_req && cpu_wren));

      #6;
      chk("rnd_gnt", host_gnt, eg);
      chk("rnd_stall", cpu_stall, est);
      chk("rnd_wren", mem_wren, ewr);
      chk("rnd_addr", mem_addr, ead);
      chk("rnd_wdata", mem_wdata, ewd);
      chk("rnd_rvalid", host_rvalid, ev);
      chk("rnd_rdata", host_rdata, erd);

      if (reset) begin
        ev = 1'b0; erd = 4'h0; denied = 0;
      end else begin
        ev = eg && !host_we;
        if (ev) erd = sh[host_addr];
        if (eg || !host_req) denied = 0;
        else if (denied < MAX_WAIT) denied++;
      end
      if (ewr) sh[ead] = ewd;
      if (eg) hact = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
